// File: rtl/id_branch_hazard_unit_pkg.sv
// Shared constants for the ID-stage branch hazard logic: opcodes, FSM
// state encoding and IF/ID field positions.
package id_branch_hazard_unit_pkg;

  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;

  typedef enum logic {
    IDLE  = 1'b0,
    WAIT1 = 1'b1
  } hz_state_t;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;

endpackage

// File: rtl/id_branch_hazard_unit_classifier.sv
// Combinational beq operand hazard classifier: a load in EX needs two
// stalls, an ALU result in EX or a load in MEM needs one.
module hazard_classifier
  import id_branch_hazard_unit_pkg::*;
#(
  parameter logic [5:0] BEQ_OP = OP_BEQ
) (
  input  logic [5:0] opcode,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] idexDest,
  input  logic       idexRegWrite,
  input  logic       idexMemRead,
  input  logic [4:0] exmeDest,
  input  logic       exmeMemRead,
  output logic       load2,
  output logic       one
);

  logic is_beq;
  logic src_ex;
  logic src_me;

  assign is_beq = (opcode == BEQ_OP);
  assign src_ex = is_beq && (idexDest != 5'd0) && ((idexDest == rs) || (idexDest == rt));
  assign src_me = is_beq && (exmeDest != 5'd0) && ((exmeDest == rs) || (exmeDest == rt));

  assign load2 = idexMemRead && src_ex;
  // Priority for LOAD2 is applied here so the consumer sees disjoint classes.
  assign one   = !load2 && ((idexRegWrite && !idexMemRead && src_ex) ||
                            (exmeMemRead && src_me));

endmodule

// File: rtl/id_branch_hazard_unit.sv
// Stall/flush controller for beq resolved in ID. Optional saturating
// stall/flush statistics counters are built when HAZARD_STATS_EN is defined.
module id_branch_hazard_unit
  import id_branch_hazard_unit_pkg::*;
#(
  parameter logic [5:0] BEQ_OP = OP_BEQ,
  parameter int         STAT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] IFIDReg,
  input  logic [4:0]  idexDest,
  input  logic        idexRegWrite,
  input  logic        idexMemRead,
  input  logic [4:0]  exmeDest,
  input  logic        exmeMemRead,
  input  logic        branchTaken,
  output logic        pcWrite,
  output logic        ifidWrite,
  output logic        idexBubble,
  output logic        ifidFlush
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stallCount,
  output logic [STAT_W-1:0] flushCount
`endif
);

  hz_state_t  state;
  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       load2;
  logic       one;
  logic       stall;
  logic       flush;

  assign opcode = IFIDReg[OPC_HI:OPC_LO];
  assign rs     = IFIDReg[RS_HI:RS_LO];
  assign rt     = IFIDReg[RT_HI:RT_LO];

  hazard_classifier #(
    .BEQ_OP(BEQ_OP)
  ) u_classifier (
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .idexDest    (idexDest),
    .idexRegWrite(idexRegWrite),
    .idexMemRead (idexMemRead),
    .exmeDest    (exmeDest),
    .exmeMemRead (exmeMemRead),
    .load2       (load2),
    .one         (one)
  );

  // WAIT1 stalls regardless of what the shifted pipeline now shows.
  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    if (!rst) begin
      stall = (state == WAIT1) || load2 || one;
      flush = (opcode == BEQ_OP) && branchTaken && !stall;
    end
  end

  assign pcWrite    = !stall;
  assign ifidWrite  = !stall;
  assign idexBubble = stall;
  assign ifidFlush  = flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= load2 ? WAIT1 : IDLE;
        WAIT1:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (stall) stallCount <= sat_inc(stallCount);
      if (flush) flushCount <= sat_inc(flushCount);
    end
  end
`else
  logic unused_stat_w;
  assign unused_stat_w = (STAT_W > 0);
`endif

  logic unused_ifid;
  assign unused_ifid = ^{IFIDReg[63:32], IFIDReg[15:0]};

endmodule

// File: tb/tb_id_branch_hazard_unit.sv
// Directed bench for id_branch_hazard_unit; stats checks run when
// HAZARD_STATS_EN is defined.
module tb_id_branch_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] IFIDReg;
  logic [4:0]  idexDest;
  logic        idexRegWrite;
  logic        idexMemRead;
  logic [4:0]  exmeDest;
  logic        exmeMemRead;
  logic        branchTaken;
  logic        pcWrite;
  logic        ifidWrite;
  logic        idexBubble;
  logic        ifidFlush;
`ifdef HAZARD_STATS_EN
  logic [3:0]  stallCount;
  logic [3:0]  flushCount;
`endif

  int tests = 0;
  int fails = 0;

  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] LW  = 6'b100011;

  always #5 clk = ~clk;

  id_branch_hazard_unit #(
    .BEQ_OP(6'b000100),
    .STAT_W(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .IFIDReg     (IFIDReg),
    .idexDest    (idexDest),
    .idexRegWrite(idexRegWrite),
    .idexMemRead (idexMemRead),
    .exmeDest    (exmeDest),
    .exmeMemRead (exmeMemRead),
    .branchTaken (branchTaken),
    .pcWrite     (pcWrite),
    .ifidWrite   (ifidWrite),
    .idexBubble  (idexBubble),
    .ifidFlush   (ifidFlush)
`ifdef HAZARD_STATS_EN
    ,
    .stallCount  (stallCount),
    .flushCount  (flushCount)
`endif
  );

  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] idd, input logic irw, input logic imr,
                       input logic [4:0] emd, input logic emr, input logic bt);
    IFIDReg      = {32'hDEAD_BEEF, op, rs, rt, 16'h1234};
    idexDest     = idd;
    idexRegWrite = irw;
    idexMemRead  = imr;
    exmeDest     = emd;
    exmeMemRead  = emr;
    branchTaken  = bt;
    #1;
  endtask

  // Expected vector is {pcWrite, ifidWrite, idexBubble, ifidFlush}.
  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {pcWrite, ifidWrite, idexBubble, ifidFlush};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  localparam logic [3:0] RUN   = 4'b1100;
  localparam logic [3:0] FLUSH = 4'b1101;
  localparam logic [3:0] STALL = 4'b0010;

  initial begin
    rst = 1'b1;
    @(negedge clk);
    // Reset forces defaults even with a LOAD2 taken beq present.
    drive(BEQ, 5'd4, 5'd4, 5'd4, 1, 1, 5'd0, 0, 1);
    chk("reset_values", RUN);
    tick();
    rst = 1'b0;

    drive(BEQ, 5'd1, 5'd2, 5'd5, 1, 0, 5'd0, 0, 1);
    chk("nohaz_taken", FLUSH);
    tick();
    drive(BEQ, 5'd1, 5'd2, 5'd5, 1, 0, 5'd0, 0, 0);
    chk("nohaz_not_taken", RUN);
    tick();

    drive(BEQ, 5'd3, 5'd2, 5'd3, 1, 0, 5'd0, 0, 1);
    chk("alu_stall", STALL);
    tick();
    drive(BEQ, 5'd3, 5'd2, 5'd0, 0, 0, 5'd3, 0, 1);
    chk("alu_release", FLUSH);
    tick();

    drive(BEQ, 5'd1, 5'd4, 5'd4, 1, 1, 5'd0, 0, 1);
    chk("load_stall1", STALL);
    tick();
    drive(BEQ, 5'd1, 5'd4, 5'd0, 0, 0, 5'd0, 0, 1);
    chk("load_stall2_wait1", STALL);
    tick();
    drive(BEQ, 5'd1, 5'd4, 5'd0, 0, 0, 5'd0, 0, 1);
    chk("load_resolve", FLUSH);
    tick();

    drive(BEQ, 5'd0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0);
    chk("reg_zero", RUN);
    tick();

    drive(BEQ, 5'd7, 5'd1, 5'd0, 0, 0, 5'd7, 1, 0);
    chk("mem_load_stall", STALL);
    tick();
    drive(BEQ, 5'd7, 5'd1, 5'd0, 0, 0, 5'd0, 0, 0);
    chk("mem_load_release", RUN);
    tick();

    drive(BEQ, 5'd8, 5'd9, 5'd9, 1, 0, 5'd8, 1, 1);
    chk("dual_one_stall", STALL);
    tick();
    drive(BEQ, 5'd8, 5'd9, 5'd0, 0, 0, 5'd0, 0, 1);
    chk("dual_one_release", FLUSH);
    tick();

    drive(LW, 5'd3, 5'd3, 5'd3, 1, 1, 5'd3, 1, 1);
    chk("non_beq", RUN);
    tick();

    // Back-to-back: a ONE hazard right after WAIT1 is classified fresh.
    drive(BEQ, 5'd6, 5'd2, 5'd6, 1, 1, 5'd0, 0, 0);
    chk("b2b_load1", STALL);
    tick();
    drive(BEQ, 5'd6, 5'd2, 5'd0, 0, 0, 5'd6, 1, 0);
    chk("b2b_wait1", STALL);
    tick();
    drive(BEQ, 5'd2, 5'd5, 5'd5, 1, 0, 5'd0, 0, 1);
    chk("b2b_one", STALL);
    tick();
    drive(BEQ, 5'd2, 5'd5, 5'd0, 0, 0, 5'd0, 0, 1);
    chk("b2b_release", FLUSH);
    tick();

    drive(BEQ, 5'd4, 5'd1, 5'd4, 1, 1, 5'd0, 0, 0);
    chk("rst_mid_load", STALL);
    tick();
    rst = 1'b1;
    drive(BEQ, 5'd4, 5'd1, 5'd0, 0, 0, 5'd0, 0, 1);
    chk("rst_mid_wait1", RUN);
`ifdef HAZARD_STATS_EN
    tick();
    tests++;
    assert ({stallCount, flushCount} === 8'h00) else begin
      fails++;
      $error("FAIL stats_reset: observed %h required 00", {stallCount, flushCount});
    end
`else
    tick();
`endif
    rst = 1'b0;
    drive(BEQ, 5'd4, 5'd1, 5'd0, 0, 0, 5'd0, 0, 1);
    chk("post_rst_idle", FLUSH);
    tick();

`ifdef HAZARD_STATS_EN
    tests++;
    assert ({stallCount, flushCount} === 8'h01) else begin
      fails++;
      $error("FAIL stats_one_flush: observed %h required 01", {stallCount, flushCount});
    end
    for (int i = 0; i < 20; i++) begin
      drive(BEQ, 5'd3, 5'd2, 5'd3, 1, 0, 5'd0, 0, 0);
      tick();
    end
    tests++;
    assert (stallCount === 4'hF) else begin
      fails++;
      $error("FAIL stats_sat: observed %h required f", stallCount);
    end
    tick();
    tests++;
    assert (stallCount === 4'hF) else begin
      fails++;
      $error("FAIL stats_hold: observed %h required f", stallCount);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
